// File: rtl/kmeans_pkg.sv
// Shared FSM encoding and derived accumulator widths for the 2-cluster, 2-dimension k-means controller.
// Latency: n/a (type and function definitions only).
// Backpressure: n/a.
package kmeans_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        DIVIDE,
        UPDATE,
        DONE
    } state_t;

    // The sum of 2**addr_w samples of data_w bits needs addr_w extra bits.
    function automatic int sum_width(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    // The count must reach 2**addr_w itself, hence one extra bit.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/kmeans_serial_div.sv
// Restoring divider: one quotient bit per cycle, quotient truncated to out_w bits on output.
// Latency: W cycles after the start cycle, then a one-cycle done pulse.
// Backpressure: start is ignored while a division is running; the caller never divides by zero.
module kmeans_serial_div #(
    parameter int W     = 16,
    parameter int out_w = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     dividend,
    input  logic [W-1:0]     divisor,
    output logic [out_w-1:0] quotient,
    output logic             done
);

    localparam int CNTW = $clog2(W + 1);

    logic [W-1:0]    rem;
    logic [W-1:0]    dsr;
    logic [W-1:0]    quo;
    logic [CNTW-1:0] cnt;
    logic            run;
    logic [W:0]      shifted;
    logic [W:0]      diff;

    assign quotient = quo[out_w-1:0];

    // Trial subtraction of the divisor from the remainder shifted by one dividend bit.
    always_comb begin
        shifted = {rem, quo[W-1]};
        diff    = shifted - {1'b0, dsr};
    end

    // Iterate once per cycle; the dividend register is reused to collect quotient bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem  <= '0;
            dsr  <= '0;
            quo  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                rem <= '0;
                quo <= dividend;
                dsr <= divisor;
                cnt <= CNTW'(W);
                run <= 1'b1;
            end else if (run) begin
                if (diff[W]) begin
                    rem <= shifted[W-1:0];
                    quo <= {quo[W-2:0], 1'b0};
                end else begin
                    rem <= diff[W-1:0];
                    quo <= {quo[W-2:0], 1'b1};
                end
                cnt <= cnt - CNTW'(1);
                if (cnt == CNTW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/kmeans_k2d2_ctrl.sv
// K-means controller, 2 clusters x 2 dimensions: streams points, accumulates per cluster, divides, iterates.
// Latency: per pass qty + pipe_latency cycles, then serial division and one update cycle.
// Backpressure: none; the distance pipeline must accept one address per cycle; start is ignored while busy.
module kmeans_k2d2_ctrl
    import kmeans_pkg::*;
#(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int input_data_qty           = 256,
    parameter int pipe_latency             = 4,
    parameter int max_iterations           = 16,
    parameter int k0_d0_initial            = 0,
    parameter int k0_d1_initial            = 0,
    parameter int k1_d0_initial            = 1,
    parameter int k1_d1_initial            = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [input_data_qty_bit_width-1:0] rd_address,
    input  logic [input_data_width-1:0]         pipe_data0,
    input  logic [input_data_width-1:0]         pipe_data1,
    input  logic                                pipe_selected,
    output logic [input_data_width-1:0]         k0d0,
    output logic [input_data_width-1:0]         k0d1,
    output logic [input_data_width-1:0]         k1d0,
    output logic [input_data_width-1:0]         k1d1,
    output logic                                busy,
    output logic                                done,
    output logic                                converged,
    output logic [7:0]                          iterations
);

    localparam int DW = input_data_width;
    localparam int AW = input_data_qty_bit_width;
    localparam int SW = sum_width(DW, AW);
    localparam int CW = cnt_width(AW);
    localparam int L  = pipe_latency;

    localparam logic [AW-1:0] LAST_ADDR = AW'(input_data_qty - 1);
    localparam logic [7:0]    MAX_IT    = 8'(max_iterations);
    localparam logic [L-1:0]  SR_TOP    = L'(1) << (L - 1);
    // Centroid slots: 0 = k0d0, 1 = k0d1, 2 = k1d0, 3 = k1d1.
    localparam logic [3:0][DW-1:0] CENT_INIT = {DW'(k1_d1_initial), DW'(k1_d0_initial),
                                                DW'(k0_d1_initial), DW'(k0_d0_initial)};

    state_t             state;
    state_t             state_nxt;
    logic [L-1:0]       vld_sr;
    logic [SW-1:0]      sum00, sum01, sum10, sum11;
    logic [CW-1:0]      cnt0, cnt1;
    logic [3:0][DW-1:0] cent;
    logic [3:0][DW-1:0] new_k;
    logic [1:0]         div_idx;
    logic               div_issued;
    logic               div_start;
    logic               div_done;
    logic               div_step;
    logic               job_skip;
    logic [SW-1:0]      div_dividend;
    logic [CW-1:0]      div_divisor;
    logic [DW-1:0]      div_quo;
    logic [7:0]         iter_inc;
    logic               conv_now;

    assign k0d0 = cent[0];
    assign k0d1 = cent[1];
    assign k1d0 = cent[2];
    assign k1d1 = cent[3];

    assign iter_inc = iterations + 8'd1;
    assign conv_now = (new_k == cent);

    // Select the sum/count pair for the division job currently in progress.
    always_comb begin
        div_dividend = sum00;
        div_divisor  = cnt0;
        unique case (div_idx)
            2'd0:    begin div_dividend = sum00; div_divisor = cnt0; end
            2'd1:    begin div_dividend = sum01; div_divisor = cnt0; end
            2'd2:    begin div_dividend = sum10; div_divisor = cnt1; end
            default: begin div_dividend = sum11; div_divisor = cnt1; end
        endcase
    end

    assign job_skip  = (div_divisor == '0);
    assign div_start = (state == DIVIDE) && !job_skip && !div_issued;
    assign div_step  = (state == DIVIDE) && (job_skip || (div_issued && div_done));

    kmeans_serial_div #(
        .W     (SW),
        .out_w (DW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (SW'(div_divisor)),
        .quotient (div_quo),
        .done     (div_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic plus the state-decoded busy/done outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD:   state_nxt = STREAM;
            STREAM: if (rd_address == LAST_ADDR) state_nxt = DRAIN;
            // Leave once only the issue being consumed this cycle remains in flight.
            DRAIN:  if ((vld_sr & ~SR_TOP) == '0) state_nxt = DIVIDE;
            DIVIDE: if (div_step && div_idx == 2'd3) state_nxt = UPDATE;
            UPDATE: state_nxt = (conv_now || iter_inc == MAX_IT) ? DONE : STREAM;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address issue, issue-valid tracking, accumulation and per-pass commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_address <= '0;
            vld_sr     <= '0;
            sum00      <= '0;
            sum01      <= '0;
            sum10      <= '0;
            sum11      <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            cent       <= CENT_INIT;
            iterations <= '0;
            converged  <= 1'b0;
        end else begin
            vld_sr <= L'({vld_sr, state == STREAM});
            case (state)
                LOAD: begin
                    rd_address <= '0;
                    sum00      <= '0;
                    sum01      <= '0;
                    sum10      <= '0;
                    sum11      <= '0;
                    cnt0       <= '0;
                    cnt1       <= '0;
                    cent       <= CENT_INIT;
                    iterations <= '0;
                    converged  <= 1'b0;
                end
                STREAM: rd_address <= (rd_address == LAST_ADDR) ? '0 : rd_address + AW'(1);
                UPDATE: begin
                    rd_address <= '0;
                    cent       <= new_k;
                    iterations <= iter_inc;
                    converged  <= conv_now;
                    sum00      <= '0;
                    sum01      <= '0;
                    sum10      <= '0;
                    sum11      <= '0;
                    cnt0       <= '0;
                    cnt1       <= '0;
                end
                default: rd_address <= '0;
            endcase
            if ((state == STREAM || state == DRAIN) && vld_sr[L-1]) begin
                if (pipe_selected) begin
                    sum10 <= sum10 + SW'(pipe_data0);
                    sum11 <= sum11 + SW'(pipe_data1);
                    cnt1  <= cnt1 + CW'(1);
                end else begin
                    sum00 <= sum00 + SW'(pipe_data0);
                    sum01 <= sum01 + SW'(pipe_data1);
                    cnt0  <= cnt0 + CW'(1);
                end
            end
        end
    end

    // Walk the four division jobs; an empty cluster keeps its old centroid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_idx    <= '0;
            div_issued <= 1'b0;
            new_k      <= '0;
        end else if (state == DIVIDE) begin
            if (div_start) div_issued <= 1'b1;
            if (div_step) begin
                new_k[div_idx] <= job_skip ? cent[div_idx] : div_quo;
                div_issued     <= 1'b0;
                div_idx        <= div_idx + 2'd1;
            end
        end else begin
            div_idx    <= '0;
            div_issued <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kmeans_k2d2_ctrl.sv
// Bench for kmeans_k2d2_ctrl: echo model of the distance pipeline and a scoreboard of expected centroids.
// Latency: expectations are queued at start and popped at the pass-1 update and at the done pulse.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_kmeans_k2d2_ctrl;
    import kmeans_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int QTY  = 4;
    localparam int LAT  = 4;
    localparam int MAXI = 2;

    typedef struct {
        int k00;
        int k01;
        int k10;
        int k11;
        int conv;
        int iters;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] rd_address;
    logic [DW-1:0] pipe_data0, pipe_data1;
    logic          pipe_selected;
    logic [DW-1:0] k0d0, k0d1, k1d0, k1d1;
    logic          busy, done, converged;
    logic [7:0]    iterations;

    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;
    exp_t pass_q[$];
    exp_t fin_q[$];

    int d0_tab[4] = '{2, 4, 10, 20};
    int d1_tab[4] = '{6, 8, 1, 2};

    always #5 clk = ~clk;

    kmeans_k2d2_ctrl #(
        .input_data_width         (DW),
        .input_data_qty_bit_width (AW),
        .input_data_qty           (QTY),
        .pipe_latency             (LAT),
        .max_iterations           (MAXI),
        .k0_d0_initial            (0),
        .k0_d1_initial            (0),
        .k1_d0_initial            (1),
        .k1_d1_initial            (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rd_address    (rd_address),
        .pipe_data0    (pipe_data0),
        .pipe_data1    (pipe_data1),
        .pipe_selected (pipe_selected),
        .k0d0          (k0d0),
        .k0d1          (k0d1),
        .k1d0          (k1d0),
        .k1d1          (k1d1),
        .busy          (busy),
        .done          (done),
        .converged     (converged),
        .iterations    (iterations)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mode 0: points 2,3 in cluster 1 every pass; mode 1: all in cluster 0; mode 2: swap each pass.
    function automatic logic sel_of(input int m, input logic [7:0] it, input logic [1:0] a);
        logic base;
        base = a[1];
        if (m == 1) return 1'b0;
        if (m == 2) return base ^ it[0];
        return base;
    endfunction

    function automatic exp_t pass1_exp(input int m);
        exp_t e;
        if (m == 1) e = '{9, 4, 1, 1, 0, 1};
        else        e = '{3, 7, 15, 1, 0, 1};
        return e;
    endfunction

    function automatic exp_t final_exp(input int m);
        exp_t e;
        if (m == 1)      e = '{9, 4, 1, 1, 1, 2};
        else if (m == 2) e = '{15, 1, 3, 7, 0, 2};
        else             e = '{3, 7, 15, 1, 1, 2};
        return e;
    endfunction

    // Pipeline stand-in: echo the point and selection for the address issued LAT cycles ago.
    logic [AW-1:0] adr_pipe [LAT];
    logic [AW-1:0] echo_a;
    always @(posedge clk) begin
        adr_pipe[0] <= rd_address;
        for (int i = 1; i < LAT; i++) adr_pipe[i] <= adr_pipe[i-1];
    end
    assign echo_a        = adr_pipe[LAT-1];
    assign pipe_data0    = DW'(d0_tab[echo_a[1:0]]);
    assign pipe_data1    = DW'(d1_tab[echo_a[1:0]]);
    assign pipe_selected = sel_of(mode, iterations, echo_a[1:0]);

    // Scoreboard: compare after the first update and at every done pulse.
    int   prev_iter = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (busy && iterations == 8'd1 && prev_iter == 0) begin
                check_val("pass1_expected", pass_q.size() != 0, 1);
                if (pass_q.size() != 0) begin
                    e = pass_q.pop_front();
                    check_val("pass1_k0d0", k0d0, e.k00);
                    check_val("pass1_k0d1", k0d1, e.k01);
                    check_val("pass1_k1d0", k1d0, e.k10);
                    check_val("pass1_k1d1", k1d1, e.k11);
                    check_val("pass1_converged", converged, e.conv);
                end
            end
            if (done) begin
                check_val("done_expected", fin_q.size() != 0, 1);
                if (fin_q.size() != 0) begin
                    e = fin_q.pop_front();
                    check_val("final_k0d0", k0d0, e.k00);
                    check_val("final_k0d1", k0d1, e.k01);
                    check_val("final_k1d0", k1d0, e.k10);
                    check_val("final_k1d1", k1d1, e.k11);
                    check_val("final_converged", converged, e.conv);
                    check_val("final_iterations", iterations, e.iters);
                end
            end
            if (prev_done) check_val("done_one_cycle", done, 0);
        end
        prev_iter <= int'(iterations);
        prev_done <= done;
    end

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_busy"}, busy, 0);
        check_val({pfx, "_done"}, done, 0);
        check_val({pfx, "_rd_address"}, rd_address, 0);
        check_val({pfx, "_k0d0"}, k0d0, 0);
        check_val({pfx, "_k0d1"}, k0d1, 0);
        check_val({pfx, "_k1d0"}, k1d0, 1);
        check_val({pfx, "_k1d1"}, k1d1, 1);
        check_val({pfx, "_converged"}, converged, 0);
        check_val({pfx, "_iterations"}, iterations, 0);
    endtask

    task automatic run_case(input int m, input bit pulse, output int cyc);
        bit   pulsed;
        exp_t f;
        pulsed = 1'b0;
        mode   = m;
        f      = final_exp(m);
        pass_q.push_back(pass1_exp(m));
        fin_q.push_back(f);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (pulse && !pulsed && dut.state == DIVIDE && iterations == 8'd1) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_val("done_within_budget", done, 1);
        if (pulse) check_val("start_pulsed_in_divide", pulsed, 1);
        @(negedge clk);
        check_val("idle_after_done", busy, 0);
        repeat (3) @(negedge clk);
        check_val("held_iterations", iterations, f.iters);
        check_val("held_converged", converged, f.conv);
        check_val("held_k0d0", k0d0, f.k00);
        check_val("held_k1d0", k1d0, f.k10);
    endtask

    initial begin
        int base_cyc;
        int cyc;
        int n;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;
        @(negedge clk);

        run_case(0, 1'b0, base_cyc);
        run_case(1, 1'b0, cyc);
        run_case(2, 1'b0, cyc);
        run_case(0, 1'b1, cyc);
        check_val("cycles_with_ignored_start", cyc, base_cyc);

        // Reset in the middle of pass 2, after the centroids have moved away from their initial values.
        mode = 0;
        pass_q.push_back(pass1_exp(0));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(iterations == 8'd1 && rd_address == AW'(2) && busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("reached_mid_stream", n < 500, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("mid_reset");
        rst = 1'b1;
        @(negedge clk);

        run_case(2, 1'b0, cyc);

        check_val("pass_queue_drained", pass_q.size(), 0);
        check_val("final_queue_drained", fin_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kmeans_k2d2_ctrl.md
KMEANS_K2D2_CTRL -- requirements
Module: kmeans_k2d2_ctrl

Interface
REQ-001 SHALL have parameter input_data_width, default 8, meaning bits per dimension sample.
REQ-002 SHALL have parameter input_data_qty_bit_width, default 8, meaning RAM address width.
REQ-003 SHALL have parameter input_data_qty, default 256, meaning points per pass (1..2**input_data_qty_bit_width).
REQ-004 SHALL have parameter pipe_latency, default 4, meaning distance-pipeline latency in cycles.
REQ-005 SHALL have parameter max_iterations, default 16, meaning pass limit (>=1).
REQ-006 SHALL have parameters k0_d0_initial, k0_d1_initial, k1_d0_initial, k1_d1_initial, defaults 0,0,1,1, meaning initial centroids.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, meaning reset, synchronous and active-low.
REQ-009 SHALL have port start, input, 1, meaning a one-cycle request to run clustering.
REQ-010 SHALL have port rd_address, output, input_data_qty_bit_width, meaning the read address to both dimension RAMs.
REQ-011 SHALL have ports pipe_data0 and pipe_data1, input, input_data_width, meaning point coordinates delayed by the pipeline.
REQ-012 SHALL have port pipe_selected, input, 1, meaning the nearest-centroid index from the pipeline.
REQ-013 SHALL have ports k0d0, k0d1, k1d0, k1d1, output, input_data_width, meaning the current centroids driven to the pipeline.
REQ-014 SHALL have ports busy (1), done (1), converged (1) and iterations (8), all outputs: busy = running, done = one-cycle completion pulse, converged = result flag, iterations = passes executed.

Function
REQ-015 SHALL implement states IDLE, LOAD, STREAM, DRAIN, DIVIDE, UPDATE, DONE.
REQ-016 SHALL go IDLE->LOAD on start=1; start is ignored in every other state.
REQ-017 SHALL, in LOAD (1 cycle), set the centroids to the initial parameters, clear the accumulators, counts and iterations, then enter STREAM.
REQ-018 SHALL, in STREAM, drive rd_address 0..input_data_qty-1 on consecutive cycles, then enter DRAIN with rd_address held at 0.
REQ-019 SHALL track issue validity in a pipe_latency-deep shift register; the pipe_data and pipe_selected inputs are consumed exactly pipe_latency cycles after their address was issued.
REQ-020 SHALL, on each valid consume, add pipe_data0/1 to the sums of the selected cluster and increment that cluster's count.
REQ-021 SHALL size the sums at input_data_width+input_data_qty_bit_width bits and the counts at input_data_qty_bit_width+1 bits, with no overflow possible.
REQ-022 SHALL remain in DRAIN until the shift register is empty, then enter DIVIDE after exactly pipe_latency DRAIN cycles.
REQ-023 SHALL, in DIVIDE, compute four floor(sum/count) values serially with one divider; the quotient is truncated to input_data_width bits.
REQ-024 SHALL, when a cluster's count is 0, skip division for that cluster and keep its centroid unchanged.
REQ-025 SHALL, in UPDATE (1 cycle), increment iterations and set converged=1 if all four new values equal the old ones.
REQ-026 SHALL, in that same UPDATE cycle, commit the new values to the centroids and clear the sums and counts.
REQ-027 SHALL go UPDATE->DONE if converged or iterations==max_iterations, and UPDATE->STREAM otherwise.
REQ-028 SHALL, in DONE, pulse done for 1 cycle and then return to IDLE, holding the centroids, converged and iterations until the next LOAD.
REQ-029 SHALL hold the centroids constant during STREAM and DRAIN.
REQ-030 SHALL assert busy in every state except IDLE.

Reset
REQ-031 SHALL, while rst=0 at a clock edge, enter IDLE from any state, including mid-pass.
REQ-032 SHALL reset rd_address=0, done=0, converged=0, busy=0, iterations=0, the centroids to their initial parameters, and the sums, counts, shift register and divider to 0.

Structure
REQ-033 SHALL place the state encoding and the derived widths (sum width, count width) in a shared package kmeans_pkg.
REQ-034 SHALL instantiate one sub-module, kmeans_serial_div: a restoring divider with start/done handshake taking sum-width cycles per quotient, with divide-by-zero never issued.

Verification
REQ-035 SHALL be verified with the pipeline replaced by a bench model that echoes data and selected from rd_address after pipe_latency cycles.
REQ-036 SHALL cover reset: rst=0 for 2 cycles mid-STREAM -> IDLE, busy=0, rd_address=0, centroids=(0,0),(1,1).
REQ-037 SHALL cover one pass: qty=4, d0={2,4,10,20}, d1={6,8,1,2}, selected={0,0,1,1} -> after UPDATE, k0=(3,7), k1=(15,1), iterations=1.
REQ-038 SHALL cover an empty cluster: same data, selected all 0 -> k0=(9,4) (floor 36/4, 17/4), k1=(1,1) unchanged.
REQ-039 SHALL cover convergence: repeat REQ-037 with identical selections on pass 2 -> done pulse, converged=1, iterations=2.
REQ-040 SHALL cover the iteration limit: max_iterations=2 with selections alternating each pass -> done after pass 2, converged=0, iterations=2.
REQ-041 SHALL cover ignored start: start pulsed during DIVIDE -> no restart and final results unchanged.
